lfsr_seq_ctrl: RTL and testbench

Sequencer for a WIDTH-bit Fibonacci LFSR shift register, used as the PRBS/test-pattern source in the lab datapath. On a start request it serially loads a seed through the LFSR's serial input, then free-runs the LFSR for a programmed number of steps. Each generated state is presented with a valid strobe, and completion is signalled with a one-cycle done pulse. The LFSR register is instantiated inside this block and driven only by the controller.

---
 rtl/lfsr_seq_ctrl_pkg.sv | 23 ++
 rtl/lfsr_seq_ctrl_if.sv | 38 +++
 rtl/lfsr_seq_ctrl_core.sv | 22 ++
 rtl/lfsr_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_seq_ctrl_pkg.sv
// Shared types and helpers for the LFSR sequencer: FSM state encoding,
// default sizes and the two-tap feedback function.
package lfsr_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;
  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

  // Fibonacci feedback: XOR of the two tapped register bits.
  function automatic logic fb_bit(input logic [MAX_WIDTH-1:0] q,
                                  input logic [5:0]           tap_a,
                                  input logic [5:0]           tap_b);
    return q[tap_a] ^ q[tap_b];
  endfunction

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// Request/status bundle between a client and the LFSR sequencer.
// The lockup signal exists only when LFSR_LOCKUP_DET_EN is defined.
interface lfsr_seq_ctrl_if
  import lfsr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             start;
  logic [WIDTH-1:0] seed;
  logic [CNT_W-1:0] steps;
  logic             busy;
  logic [WIDTH-1:0] q_out;
  logic             q_valid;
  logic             done;
  logic             seed_err;
`ifdef LFSR_LOCKUP_DET_EN
  logic             lockup;
`endif

  modport master (
    output start, seed, steps,
    input  busy, q_out, q_valid, done, seed_err
`ifdef LFSR_LOCKUP_DET_EN
    , input lockup
`endif
  );

  modport slave (
    input  start, seed, steps,
    output busy, q_out, q_valid, done, seed_err
`ifdef LFSR_LOCKUP_DET_EN
    , output lockup
`endif
  );

endinterface

// File: rtl/lfsr_seq_ctrl_core.sv
// Plain WIDTH-bit shift register: on each enabled edge the state moves one
// place toward the MSB and si enters at bit 0. Feedback is chosen outside.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             si,
  output logic [WIDTH-1:0] q
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= {q[WIDTH-2:0], si};
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// LFSR sequencer: serially loads a seed (MSB first), then free-runs the LFSR
// for a programmed number of steps. Optional LFSR_LOCKUP_DET_EN aborts on an all-zero state.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int TAP_A = WIDTH - 1,
  parameter int TAP_B = WIDTH - 2
) (
  input  logic           clk,
  input  logic           rst,
  lfsr_seq_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(WIDTH);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] seed_sh;
  logic [CNT_W-1:0] steps_r;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] bit_idx;
  logic             lfsr_en;
  logic             lfsr_si;
  logic             run_shift;
  logic             q_valid_r;
  logic             seed_err_r;
  logic             seed_is_zero;
`ifdef LFSR_LOCKUP_DET_EN
  logic             lockup_hit;
  logic             lockup_r;
`endif

  assign seed_is_zero = (bus.seed == '0);

  lfsr_core #(.WIDTH(WIDTH)) u_core (
    .clk (clk),
    .rst (rst),
    .en  (lfsr_en),
    .si  (lfsr_si),
    .q   (q)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    lfsr_en   = 1'b0;
    lfsr_si   = 1'b0;
    run_shift = 1'b0;
`ifdef LFSR_LOCKUP_DET_EN
    lockup_hit = 1'b0;
`endif
    case (state)
      IDLE: if (bus.start) state_nxt = LOAD;
      LOAD: begin
        lfsr_en = 1'b1;
        lfsr_si = seed_sh[WIDTH-1];
        if (bit_idx == IDX_W'(WIDTH - 1))
          state_nxt = (steps_r == '0) ? DONE : RUN;
      end
      RUN: begin
`ifdef LFSR_LOCKUP_DET_EN
        if (q == '0) begin
          lockup_hit = 1'b1;
          state_nxt  = DONE;
        end else
`endif
        begin
          run_shift = 1'b1;
          lfsr_en   = 1'b1;
          lfsr_si   = fb_bit(MAX_WIDTH'(q), 6'(TAP_A), 6'(TAP_B));
          if (count == steps_r - CNT_W'(1)) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      seed_sh    <= '0;
      steps_r    <= '0;
      count      <= '0;
      bit_idx    <= '0;
      q_valid_r  <= 1'b0;
      seed_err_r <= 1'b0;
`ifdef LFSR_LOCKUP_DET_EN
      lockup_r   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      q_valid_r <= run_shift;
      case (state)
        IDLE: if (bus.start) begin
          // An all-zero seed would lock the LFSR, so 0...01 is used instead.
          seed_sh    <= seed_is_zero ? WIDTH'(1) : bus.seed;
          steps_r    <= bus.steps;
          bit_idx    <= '0;
          count      <= '0;
          seed_err_r <= seed_is_zero;
`ifdef LFSR_LOCKUP_DET_EN
          lockup_r   <= 1'b0;
`endif
        end
        LOAD: begin
          seed_sh <= seed_sh << 1;
          bit_idx <= bit_idx + IDX_W'(1);
        end
        RUN:     count <= count + CNT_W'(1);
        default: ;
      endcase
`ifdef LFSR_LOCKUP_DET_EN
      if (lockup_hit) lockup_r <= 1'b1;
`endif
    end
  end

  assign bus.busy     = (state == LOAD) || (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.q_out    = q;
  assign bus.q_valid  = q_valid_r;
  assign bus.seed_err = seed_err_r;
`ifdef LFSR_LOCKUP_DET_EN
  assign bus.lockup   = lockup_r;
`endif

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench for lfsr_seq_ctrl (WIDTH=4, taps x^4+x^3+1): vector table
// of full sequences plus hand-written hold-start and mid-run reset cases.
module tb_lfsr_seq_ctrl;
  import lfsr_pkg::*;

  localparam int W  = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lfsr_seq_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  lfsr_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int             n_tests = 0;
  int             n_fail  = 0;
  logic [W-1:0]   exp_q[$];
  logic [15:0]    seen;
  int             n_seen;

  typedef struct {
    logic [W-1:0]  seed;
    logic [CW-1:0] steps;
    logic [W-1:0]  exp_final;
    logic          exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference step for x^4+x^3+1: shift up, new bit 0 = q[3]^q[2].
  function automatic logic [W-1:0] model_step(input logic [W-1:0] m);
    return {m[W-2:0], m[W-1] ^ m[W-2]};
  endfunction

  task automatic push_model(input logic [W-1:0] sd, input logic [CW-1:0] st);
    logic [W-1:0] m;
    m = (sd == '0) ? W'(1) : sd;
    for (int i = 0; i < int'(st); i++) begin
      m = model_step(m);
      exp_q.push_back(m);
    end
  endtask

  // Scoreboard consumer: every q_valid must match the oldest expected state.
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (bus.q_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_q_valid", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("q_valid_value", 32'(bus.q_out), 32'(e));
      end
      if (!seen[bus.q_out]) n_seen++;
      seen[bus.q_out] = 1'b1;
    end
  end

  // Drives one request, waits (bounded) for done; done_at = edges after acceptance.
  task automatic run_seq(input logic [W-1:0] sd, input logic [CW-1:0] st,
                         input bit hold, output int done_at);
    int n;
    push_model(sd, st);
    bus.start = 1'b1;
    bus.seed  = sd;
    bus.steps = st;
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    bus.seed  = W'($urandom);
    bus.steps = CW'($urandom);
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    n = 0;
    while (bus.done !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    done_at = n;
    if (bus.done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
    check("busy_low_with_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int done_at;
    int n;
    int nv;

    vecs[0] = '{4'b1000, 8'd3,   4'b0100, 1'b0};
    vecs[1] = '{4'b1011, 8'd0,   4'b1011, 1'b0};
    vecs[2] = '{4'b0000, 8'd2,   4'b0100, 1'b1};
    vecs[3] = '{4'b0000, 8'd0,   4'b0001, 1'b1};
    vecs[4] = '{4'b0110, 8'd1,   4'b1101, 1'b0};
    vecs[5] = '{4'b0001, 8'd15,  4'b0001, 1'b0};
    vecs[6] = '{4'b1111, 8'd4,   4'b0001, 1'b0};
    vecs[7] = '{4'b0001, 8'd255, 4'b0001, 1'b0};

    bus.start = 1'b0;
    bus.seed  = '0;
    bus.steps = '0;
    seen      = '0;
    n_seen    = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q_out",    32'(bus.q_out),    32'd0);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_q_valid",  32'(bus.q_valid),  32'd0);
    check("rst_done",     32'(bus.done),     32'd0);
    check("rst_seed_err", 32'(bus.seed_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      seen   = '0;
      n_seen = 0;
      run_seq(vecs[i].seed, vecs[i].steps, 1'b0, done_at);
      check($sformatf("v%0d_done_edge", i), 32'(done_at), 32'(W + int'(vecs[i].steps)));
      check($sformatf("v%0d_final_q", i), 32'(bus.q_out), 32'(vecs[i].exp_final));
      check($sformatf("v%0d_seed_err", i), 32'(bus.seed_err), 32'(vecs[i].exp_err));
      @(posedge clk); #1;
      check($sformatf("v%0d_done_one_cycle", i), 32'(bus.done), 32'd0);
      check($sformatf("v%0d_q_hold", i), 32'(bus.q_out), 32'(vecs[i].exp_final));
      check($sformatf("v%0d_sb_empty", i), 32'(exp_q.size()), 32'd0);
      if (vecs[i].steps == 8'd15) begin
        check("max_period_distinct", 32'(n_seen), 32'd15);
        check("max_period_no_zero", 32'(seen[0]), 32'd0);
      end
    end

    // start held high: DONE must not accept it, the following IDLE cycle must.
    run_seq(4'b1000, 8'd3, 1'b1, done_at);
    check("hold_done_edge", 32'(done_at), 32'd7);
    bus.seed  = 4'b1000;
    bus.steps = 8'd3;
    push_model(4'b1000, 8'd3);
    @(posedge clk); #1;
    check("hold_idle_busy", 32'(bus.busy), 32'd0);
    check("hold_idle_done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    check("hold_reaccept_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_second_done_edge", 32'(n), 32'd7);
    check("hold_second_final_q", 32'(bus.q_out), 32'b0100);
    @(posedge clk); #1;
    check("hold_second_done_pulse", 32'(bus.done), 32'd0);
    check("hold_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset during the second RUN step aborts with no done pulse.
    push_model(4'b1000, 8'd5);
    bus.start = 1'b1;
    bus.seed  = 4'b1000;
    bus.steps = 8'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    nv = 0;
    n  = 0;
    while (nv < 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (bus.q_valid === 1'b1) nv++;
    end
    check("rst_mid_reach_step2", 32'(nv), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("rst_mid_q_out",   32'(bus.q_out),   32'd0);
    check("rst_mid_busy",    32'(bus.busy),    32'd0);
    check("rst_mid_done",    32'(bus.done),    32'd0);
    check("rst_mid_q_valid", 32'(bus.q_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rst_mid_no_done", 32'(bus.done), 32'd0);
      check("rst_mid_idle",    32'(bus.busy), 32'd0);
    end
    run_seq(4'b1011, 8'd2, 1'b0, done_at);
    check("post_rst_done_edge", 32'(done_at), 32'd6);
    check("post_rst_final_q", 32'(bus.q_out), 32'b1111);
    @(posedge clk); #1;
    check("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
